alu2_slice_sequencer: RTL and testbench

Two-port sequencer that shares one combinational 2-bit ALU slice between two requesters and runs WIDTH-bit operations through it serially, two bits per cycle. Carry is rippled from slice to slice through a register. The block sits between the requesters and the ALU slice, drives all 10 slice inputs, and samples its 6 outputs. It returns one WIDTH-bit result per accepted request.

---
 rtl/alu2_slice_sequencer_if.sv | 52 +++++
 rtl/alu2_slice_sequencer.sv | 129 ++++++++++++
 tb/tb_alu2_slice_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu2_slice_sequencer_if.sv
// Bundle of requester, ALU-slice and response signals for the 2-bit slice sequencer.
// The master modport is the environment side (requesters, slice, consumer); slave is the sequencer.
interface alu2_slice_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_fn;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_fn;
    logic             req1_cin;

    logic [9:0]       alu_pi;
    logic [5:0]       alu_po;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_zero;
    logic [2:0]       rsp_flags;

    modport master (
        output req0_valid, req0_a, req0_b, req0_fn, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_fn, req1_cin,
        input  req1_ready,
        input  alu_pi,
        output alu_po,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zero, rsp_flags,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fn, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_fn, req1_cin,
        output req1_ready,
        output alu_pi,
        input  alu_po,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zero, rsp_flags,
        input  rsp_ready
    );
endinterface

// File: rtl/alu2_slice_sequencer.sv
// Shares one combinational 2-bit ALU slice between two round-robin requesters,
// running each WIDTH-bit operation serially two bits per cycle with a registered ripple carry.
module alu2_slice_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    alu2_slice_sequencer_if.slave bus
);
    localparam int SLICES = WIDTH / 2;
    localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [KW-1:0]    r_k;
    logic             r_last;
    logic             r_carry;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_fn;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_flags;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_lastSlice;
    logic [KW:0]      w_bitIdx;

    // Round-robin: on contention the requester that was not granted last wins.
    assign w_grant0    = (r_state == IDLE) && bus.req0_valid && (!bus.req1_valid || r_last);
    assign w_grant1    = (r_state == IDLE) && bus.req1_valid && (!bus.req0_valid || !r_last);
    assign w_lastSlice = (r_k == KW'(SLICES - 1));
    assign w_bitIdx    = {r_k, 1'b0};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.alu_pi     = '0;
        bus.rsp_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req0_ready = w_grant0;
                bus.req1_ready = w_grant1;
                if (w_grant0 || w_grant1) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                bus.alu_pi = {1'b1, r_carry, r_fn, r_b[w_bitIdx +: 2], r_a[w_bitIdx +: 2]};
                if (w_lastSlice) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_k      <= '0;
            r_last   <= 1'b1;
            r_carry  <= 1'b0;
            r_id     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_fn     <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_a      <= w_grant1 ? bus.req1_a   : bus.req0_a;
                        r_b      <= w_grant1 ? bus.req1_b   : bus.req0_b;
                        r_fn     <= w_grant1 ? bus.req1_fn  : bus.req0_fn;
                        r_carry  <= w_grant1 ? bus.req1_cin : bus.req0_cin;
                        r_id     <= w_grant1;
                        r_last   <= w_grant1;
                        r_k      <= '0;
                        r_result <= '0;
                        r_flags  <= '0;
                    end
                end
                RUN: begin
                    r_result[w_bitIdx +: 2] <= bus.alu_po[1:0];
                    r_carry                 <= bus.alu_po[2];
                    r_flags                 <= r_flags | bus.alu_po[5:3];
                    if (!w_lastSlice) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // After the last slice the carry register holds the final carry-out.
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_result;
    assign bus.rsp_cout   = r_carry;
    assign bus.rsp_zero   = (r_result == '0);
    assign bus.rsp_flags  = r_flags;

endmodule

// File: tb/tb_alu2_slice_sequencer.sv
// Self-checking bench: a 2-bit adder slice model, a cycle-level reference model of the
// sequencer protocol, and a scoreboard of expected results pushed at each grant.
module tb_alu2_slice_sequencer;
    localparam int WIDTH  = 8;
    localparam int SLICES = WIDTH / 2;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             cout;
        logic             zero;
        logic [2:0]       flags;
        logic             id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu2_slice_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu2_slice_sequencer #(.WIDTH(WIDTH)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // Slice model: 2-bit adder, flag0 marks a zero result pair.
    logic [2:0] sliceSum;
    always_comb begin
        sliceSum   = {1'b0, bus.alu_pi[1:0]} + {1'b0, bus.alu_pi[3:2]} + {2'b00, bus.alu_pi[8]};
        bus.alu_po = {2'b00, (sliceSum[1:0] == 2'b00), sliceSum};
    end

    int   compared   = 0;
    int   mismatched = 0;
    exp_t expQ[$];
    int   grantLog[$];
    int   rspCount = 0;

    int               phase = 0;
    int               runIdx = 0;
    logic             mLast = 1'b1;
    logic [WIDTH-1:0] curA, curB;
    logic [3:0]       curFn;
    logic             curCarry;
    logic [9:0]       expPi;
    logic             expR0, expR1;
    logic [2:0]       pairSum;
    exp_t             headExp;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic exp_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic cin, input logic id);
        exp_t         r;
        logic [WIDTH:0] sum;
        logic [2:0]   p;
        logic         c;
        sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        r.result = sum[WIDTH-1:0];
        r.cout   = sum[WIDTH];
        r.zero   = (sum[WIDTH-1:0] == '0);
        r.flags  = 3'b000;
        r.id     = id;
        c        = cin;
        for (int i = 0; i < SLICES; i++) begin
            p = {1'b0, a[2*i +: 2]} + {1'b0, b[2*i +: 2]} + {2'b00, c};
            if (p[1:0] == 2'b00) r.flags[0] = 1'b1;
            c = p[2];
        end
        return r;
    endfunction

    // Reference protocol model, evaluated once per cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            phase    = 0;
            runIdx   = 0;
            mLast    = 1'b1;
            rspCount = 0;
            expQ.delete();
            grantLog.delete();
        end else begin
            expPi = '0;
            if (phase == 1) begin
                expPi = {1'b1, curCarry, curFn, curB[2*runIdx +: 2], curA[2*runIdx +: 2]};
            end
            checkOutput("aluPi", {22'd0, bus.alu_pi}, {22'd0, expPi});

            expR0 = (phase == 0) && bus.req0_valid && (!bus.req1_valid || mLast);
            expR1 = (phase == 0) && bus.req1_valid && (!bus.req0_valid || !mLast);
            checkOutput("reqReady", {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, expR1, expR0});
            checkOutput("rspValid", {31'd0, bus.rsp_valid}, {31'd0, (phase == 2)});

            if (phase == 2) begin
                if (expQ.size() == 0) begin
                    checkOutput("rspQueueEmpty", 32'd0, 32'd1);
                end else begin
                    headExp = expQ[0];
                    checkOutput("rspResult", {24'd0, bus.rsp_result}, {24'd0, headExp.result});
                    checkOutput("rspCout",   {31'd0, bus.rsp_cout},   {31'd0, headExp.cout});
                    checkOutput("rspZero",   {31'd0, bus.rsp_zero},   {31'd0, headExp.zero});
                    checkOutput("rspFlags",  {29'd0, bus.rsp_flags},  {29'd0, headExp.flags});
                    checkOutput("rspId",     {31'd0, bus.rsp_id},     {31'd0, headExp.id});
                end
            end

            if (phase == 1) begin
                pairSum  = {1'b0, curA[2*runIdx +: 2]} + {1'b0, curB[2*runIdx +: 2]} + {2'b00, curCarry};
                curCarry = pairSum[2];
                runIdx++;
                if (runIdx == SLICES) phase = 2;
            end else if (phase == 2 && bus.rsp_ready) begin
                if (expQ.size() > 0) void'(expQ.pop_front());
                rspCount++;
                phase = 0;
            end else if (phase == 0 && (expR0 || expR1)) begin
                curA     = expR1 ? bus.req1_a   : bus.req0_a;
                curB     = expR1 ? bus.req1_b   : bus.req0_b;
                curFn    = expR1 ? bus.req1_fn  : bus.req0_fn;
                curCarry = expR1 ? bus.req1_cin : bus.req0_cin;
                mLast    = expR1;
                expQ.push_back(refModel(curA, curB, curCarry, expR1));
                grantLog.push_back(expR1 ? 1 : 0);
                runIdx = 0;
                phase  = 1;
            end
        end
    end

    task automatic driveReq(input int port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [3:0] fn, input logic cin);
        if (port == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_fn = fn; bus.req0_cin = cin;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_fn = fn; bus.req1_cin = cin;
        end
    endtask

    task automatic waitGrant(input int port);
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((port == 0 && bus.req0_ready) || (port == 1 && bus.req1_ready)) begin
                got = 1;
                break;
            end
        end
        if (!got) checkOutput("grantTimeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [3:0] fn, input logic cin);
        @(posedge clk);
        #1;
        driveReq(port, a, b, fn, cin);
        waitGrant(port);
    endtask

    task automatic waitResponses(input int target);
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (rspCount >= target) begin
                got = 1;
                break;
            end
        end
        if (!got) checkOutput("rspTimeout", rspCount, target);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rspValid"},  {31'd0, bus.rsp_valid},  32'd0);
        checkOutput({tag, "_rspId"},     {31'd0, bus.rsp_id},     32'd0);
        checkOutput({tag, "_ready"},     {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        checkOutput({tag, "_aluPi"},     {22'd0, bus.alu_pi},     32'd0);
        checkOutput({tag, "_rspResult"}, {24'd0, bus.rsp_result}, 32'd0);
        checkOutput({tag, "_rspFlags"},  {29'd0, bus.rsp_flags},  32'd0);
        checkOutput({tag, "_rspCout"},   {31'd0, bus.rsp_cout},   32'd0);
        checkOutput({tag, "_rspZero"},   {31'd0, bus.rsp_zero},   32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        bit seen;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_fn = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_fn = '0; bus.req1_cin = 1'b0;
        bus.rsp_ready  = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single add on req0 with explicit grant-to-valid latency.
        applyStimulus(0, 8'h5A, 8'h3C, 4'h3, 1'b0);
        lat = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                seen = 1;
                break;
            end
        end
        checkOutput("rspLatency", seen ? lat : 0, SLICES + 1);
        checkOutput("addResult", {24'd0, bus.rsp_result}, 32'h96);
        waitResponses(1);

        // Carry ripples through every slice.
        applyStimulus(1, 8'hFF, 8'h01, 4'hA, 1'b0);
        waitResponses(2);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                          4'($urandom), 1'($urandom));
            waitResponses(3 + i);
        end

        // Contention from reset: grants must alternate starting with req0.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset2");
        @(posedge clk);
        #1 rst_n = 1'b1;
        driveReq(0, 8'h01, 8'h01, 4'h0, 1'b0);
        driveReq(1, 8'h01, 8'h01, 4'h0, 1'b0);
        waitResponses(4);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checkOutput("grantCount", grantLog.size(), 4);
        for (int i = 0; i < 4 && i < grantLog.size(); i++) begin
            checkOutput("grantOrder", grantLog[i], i % 2);
        end

        // Backpressure: response held while req1 waits.
        bus.rsp_ready = 1'b0;
        applyStimulus(0, 8'h33, 8'h44, 4'h5, 1'b1);
        driveReq(1, 8'h80, 8'h80, 4'h6, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1;
                break;
            end
        end
        checkOutput("bpDoneSeen", {31'd0, seen}, 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("bpReq1Waiting", {31'd0, bus.req1_ready}, 32'd0);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        waitGrant(1);
        waitResponses(6);

        // Reset in the middle of RUN at slice 2 discards the operation.
        applyStimulus(0, 8'hA5, 8'h5A, 4'h7, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkResetValues("midRunReset");
        repeat (4) @(negedge clk);
        applyStimulus(0, 8'h12, 8'h34, 4'h1, 1'b1);
        waitResponses(1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
